// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// STEP_MAX bounds how far the per-cycle step shifter moves the accumulator.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int STEP_MAX = 3;

endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: combinational 0-3 position logical left shift, zero fill.
// No state, no handshake; result follows din/sel in the same cycle.
module shift_step #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    dout = din;
    case (sel)
      2'd0: dout = din;
      2'd1: dout = din << 1;
      2'd2: dout = din << 2;
      2'd3: dout = din << 3;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical left shifter: up to 3 positions per cycle, one request in flight.
// Optional out_zero/out_carry flags are built when SHIFT_FLAGS_EN is defined.
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef SHIFT_FLAGS_EN
  ,
  output logic              out_zero,
  output logic              out_carry
`endif
);

  import shift_sequencer_pkg::*;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [AMT_W-1:0]   rem_next;
  logic [1:0]         step_sel;
  logic [DATA_W-1:0]  shifted;

  always_comb begin
    step_sel = (rem_q > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];
    rem_next = rem_q - AMT_W'(step_sel);
  end

  shift_step #(.DATA_W(DATA_W)) u_step (
    .din  (acc_q),
    .sel  (step_sel),
    .dout (shifted)
  );

`ifdef SHIFT_FLAGS_EN
  logic carry_q, carry_d;
  logic step_carry;

  // The lowest bit leaving the top is the last one shifted out this step.
  always_comb begin
    step_carry = carry_q;
    case (step_sel)
      2'd1: step_carry = acc_q[DATA_W-1];
      2'd2: step_carry = acc_q[DATA_W-2];
      2'd3: step_carry = acc_q[DATA_W-3];
      default: step_carry = carry_q;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SHIFT_FLAGS_EN
    carry_d   = carry_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          rem_d   = in_amt;
          state_d = (in_amt == '0) ? DONE : SHIFT;
`ifdef SHIFT_FLAGS_EN
          carry_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        acc_d = shifted;
        rem_d = rem_next;
`ifdef SHIFT_FLAGS_EN
        carry_d = step_carry;
`endif
        if (rem_next == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // A simultaneous in_valid is not accepted until back in IDLE.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SHIFT_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign out_zero  = (acc_q == '0);
  assign out_carry = carry_q;
`endif

  assign out_data = acc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; flag checks compile in with SHIFT_FLAGS_EN.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
`ifdef SHIFT_FLAGS_EN
  logic        out_zero;
  logic        out_carry;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  shift_sequencer #(.DATA_W(16), .AMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SHIFT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ev;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_amt    = 4'd0;
    out_ready = 1'b1;
    #2;
    chk1 ("rst_in_ready",  in_ready,  1'b1);
    chk1 ("rst_out_valid", out_valid, 1'b0);
    chk1 ("rst_busy",      busy,      1'b0);
    chk16("rst_out_data",  out_data,  16'h0000);
`ifdef SHIFT_FLAGS_EN
    chk1 ("rst_out_carry", out_carry, 1'b0);
`endif
    edge1();
    rst_n = 1'b1;
    edge1();

    // 0x0001 << 15: five shift cycles, out_valid after 6th edge
    in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'd15;
    edge1();
    in_valid = 1'b0;
    chk1 ("a15_busy",     busy,     1'b1);
    chk1 ("a15_in_ready", in_ready, 1'b0);
    for (int e = 2; e <= 5; e++) begin
      edge1();
      ev = 16'(32'd1 << (3 * (e - 1)));
      chk1 ("a15_no_valid", out_valid, 1'b0);
      chk16("a15_partial",  out_data,  ev);
    end
    edge1();
    chk1 ("a15_valid", out_valid, 1'b1);
    chk16("a15_data",  out_data,  16'h8000);
`ifdef SHIFT_FLAGS_EN
    chk1 ("a15_carry", out_carry, 1'b0);
    chk1 ("a15_zero",  out_zero,  1'b0);
`endif
    edge1();
    chk1 ("a15_idle_valid", out_valid, 1'b0);
    chk1 ("a15_idle_ready", in_ready,  1'b1);

    // amount 0 goes straight to DONE; new in_valid held through DONE+out_ready
    in_valid = 1'b1; in_data = 16'h1234; in_amt = 4'd0;
    edge1();
    in_data = 16'h00F0; in_amt = 4'd12;
    chk1 ("a0_valid", out_valid, 1'b1);
    chk16("a0_data",  out_data,  16'h1234);
`ifdef SHIFT_FLAGS_EN
    chk1 ("a0_zero",  out_zero,  1'b0);
    chk1 ("a0_carry", out_carry, 1'b0);
`endif
    edge1();
    chk1 ("done_to_idle_only", busy,     1'b0);
    chk1 ("idle_ready_again",  in_ready, 1'b1);
    chk16("idle_acc_held",     out_data, 16'h1234);

    // 0x00F0 << 12: accepted now, four SHIFT cycles
    edge1();
    in_valid = 1'b0;
    chk1 ("a12_busy", busy,     1'b1);
    chk16("a12_load", out_data, 16'h00F0);
    for (int e = 1; e <= 3; e++) begin
      edge1();
      chk1("a12_no_valid", out_valid, 1'b0);
    end
    edge1();
    chk1 ("a12_valid", out_valid, 1'b1);
    chk16("a12_data",  out_data,  16'h0000);
`ifdef SHIFT_FLAGS_EN
    chk1 ("a12_zero",  out_zero,  1'b1);
    chk1 ("a12_carry", out_carry, 1'b1);
`endif
    edge1();

    // 0xFFFF << 4 with consumer stalled; extra request must be ignored
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hFFFF; in_amt = 4'd4;
    edge1();
    in_valid = 1'b0;
    edge1();
    chk16("a4_step1", out_data, 16'hFFF8);
    edge1();
    chk1 ("a4_valid", out_valid, 1'b1);
    chk16("a4_data",  out_data,  16'hFFF0);
    in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'd0;
    for (int e = 1; e <= 5; e++) begin
      edge1();
      chk1 ("stall_valid",    out_valid, 1'b1);
      chk16("stall_data",     out_data,  16'hFFF0);
      chk1 ("stall_in_ready", in_ready,  1'b0);
    end
`ifdef SHIFT_FLAGS_EN
    chk1 ("a4_carry", out_carry, 1'b1);
    chk1 ("a4_zero",  out_zero,  1'b0);
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    edge1();
    chk1 ("a4_idle_valid", out_valid, 1'b0);
    chk1 ("a4_idle_ready", in_ready,  1'b1);
    chk16("a4_idle_data",  out_data,  16'hFFF0);

    // reset during the second SHIFT cycle of 0x8001 << 7
    in_valid = 1'b1; in_data = 16'h8001; in_amt = 4'd7;
    edge1();
    in_valid = 1'b0;
    edge1();
    chk16("a7_step1", out_data, 16'h0008);
    rst_n = 1'b0;
    #1;
    chk1 ("mid_rst_busy",     busy,      1'b0);
    chk1 ("mid_rst_in_ready", in_ready,  1'b1);
    chk1 ("mid_rst_valid",    out_valid, 1'b0);
    chk16("mid_rst_data",     out_data,  16'h0000);
    edge1();
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      edge1();
      chk1("post_rst_no_valid", out_valid, 1'b0);
    end

    in_valid = 1'b1; in_data = 16'h8001; in_amt = 4'd1;
    edge1();
    in_valid = 1'b0;
    chk1("a1_no_valid", out_valid, 1'b0);
    edge1();
    chk1 ("a1_valid", out_valid, 1'b1);
    chk16("a1_data",  out_data,  16'h0002);
`ifdef SHIFT_FLAGS_EN
    chk1 ("a1_carry", out_carry, 1'b1);
`endif
    edge1();
    chk1("a1_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
